// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: skid-buffer occupancy
// encoding, default word width and the packet counter width.
package fifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int PKT_CNT_W      = 16;

    // Number of words held for a given occupancy state.
    function automatic logic [1:0] occ_to_num(input occ_t occ);
        case (occ)
            OCC_ONE: occ_to_num = 2'd1;
            OCC_TWO: occ_to_num = 2'd2;
            default: occ_to_num = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry data+last holding buffer. Entry 0 is the head and drives the
// stream outputs directly from flops. A push together with a pop in the
// one-entry state replaces the head. The caller never pushes while full.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_head_last,
    output logic                  o_valid,
    output occ_t                  o_occ
);

    occ_t                  r_state;
    occ_t                  w_next;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_l0;
    logic                  r_l1;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= OCC_EMPTY;
        else       r_state <= w_next;
    end

    // Occupancy transitions from push/pop.
    always_comb begin
        w_next = r_state;
        case (r_state)
            OCC_EMPTY: if (i_push) w_next = OCC_ONE;
            OCC_ONE: begin
                if (i_push && !i_pop)      w_next = OCC_TWO;
                else if (!i_push && i_pop) w_next = OCC_EMPTY;
            end
            OCC_TWO:   if (i_pop) w_next = OCC_ONE;
            default:   w_next = OCC_EMPTY;
        endcase
    end

    // Entry storage: fill head when empty, tail when one is held, shift on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0 <= '0;
            r_l0 <= 1'b0;
            r_d1 <= '0;
            r_l1 <= 1'b0;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (i_push) begin
                        r_d0 <= i_data;
                        r_l0 <= i_last;
                    end
                end
                OCC_ONE: begin
                    if (i_push && i_pop) begin
                        r_d0 <= i_data;
                        r_l0 <= i_last;
                    end else if (i_push) begin
                        r_d1 <= i_data;
                        r_l1 <= i_last;
                    end
                end
                OCC_TWO: begin
                    if (i_pop) begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Head entry drives the stream; occupancy exposed for observation.
    always_comb begin
        o_head_data = r_d0;
        o_head_last = r_l0;
        o_valid     = (r_state != OCC_EMPTY);
        o_occ       = r_state;
    end

endmodule

// File: rtl/fifo_packetizer.sv
// Read stage for the synchronous FIFO: issues reads so that words already in
// flight always have a buffer slot, captures the returned word one cycle
// later and streams it out with a last flag every PKT_LEN beats.
// Optional: define FIFO_PACKETIZER_PKT_CNT_EN to add the 16-bit pkt_count
// output counting completed packets.
module fifo_packetizer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_error,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  err
`ifdef FIFO_PACKETIZER_PKT_CNT_EN
    ,
    output logic [PKT_CNT_W-1:0]  pkt_count
`endif
);

    localparam int              CNT_W       = $clog2(PKT_LEN) + 1;
    localparam logic [CNT_W:0]  LP_LEN      = (CNT_W + 1)'(PKT_LEN);
    localparam logic [CNT_W:0]  LP_LAST_IDX = (CNT_W + 1)'(PKT_LEN - 1);

    logic             r_inflight;
    logic             r_err;
    logic [CNT_W-1:0] r_beat;
    logic [CNT_W-1:0] w_beat_next;
    logic [CNT_W:0]   w_new_idx;
    logic [1:0]       w_ahead;
    logic [2:0]       w_load;
    logic             w_pop;
    logic             w_push;
    logic             w_new_last;
    occ_t             w_occ;

    // Stream handshake: valid/ready both high at the clock edge moves one
    // beat; m_data/m_last hold while valid is high and ready is low.
    assign w_pop  = m_valid & m_ready;
    assign w_push = r_inflight;

    // Read only when the word would still have a slot after this cycle's pop.
    always_comb begin
        w_load     = {1'b0, occ_to_num(w_occ)} + {2'b00, r_inflight} - {2'b00, w_pop};
        fifo_rd_en = !reset && !fifo_empty && (w_load < 3'd2);
    end

    // Beat index of the captured word = head index after this cycle's pop
    // plus the entries that remain ahead of it, modulo PKT_LEN.
    always_comb begin
        w_beat_next = r_beat;
        if (w_pop) w_beat_next = m_last ? '0 : r_beat + 1'b1;
        w_ahead   = occ_to_num(w_occ) - {1'b0, w_pop};
        w_new_idx = (CNT_W + 1)'(w_beat_next) + (CNT_W + 1)'(w_ahead);
        if (w_new_idx >= LP_LEN) w_new_idx = w_new_idx - LP_LEN;
        w_new_last = (w_new_idx == LP_LAST_IDX);
    end

    // Read-return tracking, head beat index and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_beat     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_beat     <= w_beat_next;
            r_err      <= r_err | fifo_error;
        end
    end

    assign err = r_err;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (fifo_data_out),
        .i_last      (w_new_last),
        .o_head_data (m_data),
        .o_head_last (m_last),
        .o_valid     (m_valid),
        .o_occ       (w_occ)
    );

`ifdef FIFO_PACKETIZER_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] r_pkt_count;

    // Completed packets: one per accepted last beat, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset)                r_pkt_count <= '0;
        else if (w_pop && m_last) r_pkt_count <= r_pkt_count + 1'b1;
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_fifo_packetizer.sv
// Bench for fifo_packetizer: behavioural FIFO with one-cycle read latency,
// a reference list of expected beats (data plus last flag derived from each
// word's position in the overall word sequence) and an independent monitor.
module tb_fifo_packetizer;

    localparam int DW = 32;
    localparam int PL = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_error = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          err;
`ifdef FIFO_PACKETIZER_PKT_CNT_EN
    logic [15:0]   pkt_count;
`endif

    fifo_packetizer #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_error    (fifo_error),
        .fifo_rd_en    (fifo_rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .err           (err)
`ifdef FIFO_PACKETIZER_PKT_CNT_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    int            beat_idx = 0;
    int            pkt_exp = 0;
    int            rd_count = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic          err_exp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Write one word into the FIFO model and record its expected beat.
    task automatic push_word(input logic [DW-1:0] d);
        logic is_last;
        is_last = ((beat_idx % PL) == PL - 1);
        fifo_q.push_back(d);
        exp_q.push_back({is_last, d});
        beat_idx++;
        fifo_empty = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick(input logic rdy);
        logic rd;
        m_ready = rdy;
        #1;
        rd = fifo_rd_en;
        if (rd) begin
            rd_count++;
            check("no_read_when_empty", fifo_empty, 0);
        end
        @(posedge clk);
        if (reset) err_exp = 1'b0;
        else if (fifo_error) err_exp = 1'b1;
        #1;
        if (rd && fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
        fifo_error = 1'b0;
        check("err", err, err_exp);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick(1'b1);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    // Monitor: compares every accepted beat and checks hold-while-stalled.
    initial begin : monitor
        logic          prev_hold;
        logic [DW:0]   prev_beat;
        logic [DW:0]   e;
        prev_hold = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_beat", {m_last, m_data}, prev_beat);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_beat: got %0h expected none", {m_last, m_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {m_last, m_data}, e);
                        if (e[DW]) pkt_exp++;
                    end
                end
                prev_hold = m_valid && !m_ready;
                prev_beat = {m_last, m_data};
            end
        end
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int wr;
        int n;
        // Reset state and read gating during reset.
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_err", err, 0);
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        #1;
        check("rd_gated_by_reset", fifo_rd_en, 0);
        reset = 1'b0;

        // Test 1: 16 preloaded words, ready always high.
        rd_count = 0;
        tick(1'b1);
        check("first_rd", rd_count, 1);
        check("lat_cycle1_valid", m_valid, 0);
        tick(1'b1);
        check("lat_cycle2_valid", m_valid, 1);
        check("lat_cycle2_data", m_data, 0);
        for (int i = 1; i < 16; i++) begin
            tick(1'b1);
            check("stream_continuous", m_valid, 1);
        end
        drain();

        // Test 2: backpressure with 4 words.
        for (int i = 0; i < 4; i++) push_word(DW'(i));
        rd_count = 0;
        repeat (6) tick(1'b0);
        check("stall_reads", rd_count, 2);
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, 0);
        drain();

        // Test 3: random writes and random ready over 100 words.
        wr = 0;
        n = 0;
        while ((wr < 100 || exp_q.size() > 0) && n < 3000) begin
            if (wr < 100 && $urandom_range(0, 1) == 1) begin
                push_word($urandom);
                wr++;
            end
            tick(1'($urandom_range(0, 1)));
            n++;
        end
        check("random_done", exp_q.size(), 0);

        // Test 4: FIFO runs dry mid-packet, then resumes.
        for (int i = 0; i < 5; i++) push_word(DW'(32'hA0 + i));
        repeat (15) tick(1'b1);
        check("gap_valid", m_valid, 0);
        check("gap_drained", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) push_word(DW'(32'hB0 + i));
        drain();

        // Test 5: reset while buffer is full under backpressure.
        for (int i = 0; i < 6; i++) push_word(DW'(32'hC0 + i));
        repeat (4) tick(1'b0);
        check("pre_reset_valid", m_valid, 1);
        reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        beat_idx = 0;
        pkt_exp = 0;
        fifo_empty = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_data", m_data, 0);
`ifdef FIFO_PACKETIZER_PKT_CNT_EN
        check("mid_rst_pkt_count", pkt_count, 0);
`endif

        // Test 6: refill from index 0 with an error pulse mid-stream.
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            if (i == 5) fifo_error = 1'b1;
            tick(1'b1);
        end
        check("err_drain_done", exp_q.size(), 0);
        check("err_sticky", err, 1);
        check("pkts_seen", pkt_exp, 2);
`ifdef FIFO_PACKETIZER_PKT_CNT_EN
        check("pkt_count", pkt_count, 16'd2);
`endif
        repeat (3) tick(1'b1);
        check("err_still_set", err, 1);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        check("err_cleared", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
